// File: rtl/fpu_div_ctrl.sv
// -----------------------------------------------------------------------------
// fpu_div_ctrl
//   FP32 divide front/back end wrapped around a sequential mantissa divider.
//   It unpacks two IEEE-754 single-precision operands and resolves special
//   cases (NaN, zero, infinity) without touching the divider. For ordinary
//   operands it launches the divider through a level start/done handshake.
//   It then normalises, truncates and packs the quotient.
//
// Ports
//   clk, arst_n     clock (rising edge) and asynchronous active-low reset
//   start           host request, sampled only while idle
//   a_in, b_in      dividend / divisor, FP32
//   busy            high in every state except IDLE
//   done            one-cycle pulse; result/flags valid from then until next start
//   result          FP32 quotient
//   flags           {invalid, div_by_zero, overflow, underflow}
//   div_dividend    {1,frac_a} to the mantissa divider
//   div_divisor     {1,frac_b} to the mantissa divider
//   div_start       divider request (level)
//   div_done        divider completion (level)
//   div_quotient    floor(div_dividend * 2^23 / div_divisor), valid with div_done
// -----------------------------------------------------------------------------
module fpu_div_ctrl #(
    parameter int          MANT_W      = 24,
    parameter logic [31:0] QNAN        = 32'h7FC00000,
    parameter int          DIV_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic [31:0]       a_in,
    input  logic [31:0]       b_in,
    output logic              busy,
    output logic              done,
    output logic [31:0]       result,
    output logic [3:0]        flags,
    output logic [MANT_W-1:0] div_dividend,
    output logic [MANT_W-1:0] div_divisor,
    output logic              div_start,
    input  logic              div_done,
    input  logic [MANT_W-1:0] div_quotient
);

    localparam int CNT_W = $clog2(DIV_TIMEOUT + 2) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_DIV_WAIT,
        S_NORM,
        S_PACK
    } state_t;

    // flag bit positions inside flags
    localparam int F_INV = 3;
    localparam int F_DBZ = 2;
    localparam int F_OVF = 1;
    localparam int F_UNF = 0;

    state_t             state_q, state_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic               sign_q, sign_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [MANT_W-1:0]  quot_q, quot_d;
    logic [31:0]        res_pend_q, res_pend_d;
    logic [3:0]         flg_pend_q, flg_pend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [31:0]        result_q, result_d;
    logic [3:0]         flags_q, flags_d;
    logic [MANT_W-1:0]  div_dividend_q, div_dividend_d;
    logic [MANT_W-1:0]  div_divisor_q, div_divisor_d;
    logic               div_start_q, div_start_d;

    // Normalise the divider quotient, truncate, and pack. Returns {flags, result}.
    // The quotient of two mantissas in [1,2) lies in [0.5,2), so at most one
    // left shift is ever needed.
    function automatic logic [35:0] norm_pack(input logic s,
                                              input logic signed [9:0] e_in,
                                              input logic [23:0] q);
        logic signed [9:0] e;
        logic [23:0]       m;
        e = e_in;
        m = q;
        if (!q[23]) begin
            m = {q[22:0], 1'b0};
            e = e_in - 10'sd1;
        end
        if (e >= 10'sd255)
            return {4'b0010, s, 8'hFF, 23'd0};
        else if (e <= 10'sd0)
            return {4'b0001, s, 31'd0};
        else
            return {4'b0000, s, e[7:0], m[22:0]};
    endfunction

    // Operand classification; subnormals are treated as zero.
    logic       a_exp_max, b_exp_max;
    logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic       sign_ab;

    always_comb begin
        a_exp_max = (a_q[30:23] == 8'hFF);
        b_exp_max = (b_q[30:23] == 8'hFF);
        a_nan     = a_exp_max && (a_q[22:0] != 23'd0);
        b_nan     = b_exp_max && (b_q[22:0] != 23'd0);
        a_inf     = a_exp_max && (a_q[22:0] == 23'd0);
        b_inf     = b_exp_max && (b_q[22:0] == 23'd0);
        a_zero    = (a_q[30:23] == 8'h00);
        b_zero    = (b_q[30:23] == 8'h00);
        sign_ab   = a_q[31] ^ b_q[31];
    end

    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        b_d            = b_q;
        sign_d         = sign_q;
        exp_d          = exp_q;
        quot_d         = quot_q;
        res_pend_d     = res_pend_q;
        flg_pend_d     = flg_pend_q;
        cnt_d          = cnt_q;
        done_d         = 1'b0;
        result_d       = result_q;
        flags_d        = flags_q;
        div_dividend_d = div_dividend_q;
        div_divisor_d  = div_divisor_q;
        div_start_d    = div_start_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    flags_d = 4'b0000;
                    state_d = S_UNPACK;
                end
            end

            S_UNPACK: begin
                sign_d     = sign_ab;
                flg_pend_d = 4'b0000;
                if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                    res_pend_d        = QNAN;
                    flg_pend_d[F_INV] = 1'b1;
                    state_d           = S_PACK;
                end else if (a_inf) begin
                    res_pend_d = {sign_ab, 8'hFF, 23'd0};
                    state_d    = S_PACK;
                end else if (b_zero) begin
                    res_pend_d        = {sign_ab, 8'hFF, 23'd0};
                    flg_pend_d[F_DBZ] = 1'b1;
                    state_d           = S_PACK;
                end else if (a_zero || b_inf) begin
                    res_pend_d = {sign_ab, 31'd0};
                    state_d    = S_PACK;
                end else begin
                    div_dividend_d = {1'b1, a_q[22:0]};
                    div_divisor_d  = {1'b1, b_q[22:0]};
                    exp_d          = $signed({2'b00, a_q[30:23]})
                                   - $signed({2'b00, b_q[30:23]}) + 10'sd127;
                    cnt_d          = '0;
                    // A done still high from an earlier transaction must clear
                    // before a new request may be raised.
                    if (!div_done) begin
                        div_start_d = 1'b1;
                        state_d     = S_DIV_WAIT;
                    end
                end
            end

            S_DIV_WAIT: begin
                if (div_done) begin
                    quot_d      = div_quotient;
                    div_start_d = 1'b0;
                    state_d     = S_NORM;
                end else if ((DIV_TIMEOUT > 0) &&
                             ((cnt_q + CNT_W'(2)) >= CNT_W'(DIV_TIMEOUT))) begin
                    // Fire one cycle early so done lands exactly DIV_TIMEOUT
                    // cycles after div_start rose (PACK adds the last cycle).
                    div_start_d = 1'b0;
                    res_pend_d  = QNAN;
                    flg_pend_d  = 4'b1000;
                    state_d     = S_PACK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_NORM: begin
                {flg_pend_d, res_pend_d} = norm_pack(sign_q, exp_q, quot_q);
                state_d = S_PACK;
            end

            S_PACK: begin
                result_d = res_pend_q;
                flags_d  = flg_pend_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q        <= S_IDLE;
            a_q            <= '0;
            b_q            <= '0;
            sign_q         <= 1'b0;
            exp_q          <= '0;
            quot_q         <= '0;
            res_pend_q     <= '0;
            flg_pend_q     <= '0;
            cnt_q          <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_q       <= '0;
            flags_q        <= '0;
            div_dividend_q <= '0;
            div_divisor_q  <= '0;
            div_start_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            b_q            <= b_d;
            sign_q         <= sign_d;
            exp_q          <= exp_d;
            quot_q         <= quot_d;
            res_pend_q     <= res_pend_d;
            flg_pend_q     <= flg_pend_d;
            cnt_q          <= cnt_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            result_q       <= result_d;
            flags_q        <= flags_d;
            div_dividend_q <= div_dividend_d;
            div_divisor_q  <= div_divisor_d;
            div_start_q    <= div_start_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign result       = result_q;
    assign flags        = flags_q;
    assign div_dividend = div_dividend_q;
    assign div_divisor  = div_divisor_q;
    assign div_start    = div_start_q;

endmodule

// File: tb/tb_fpu_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fpu_div_ctrl
//   Directed bench for fpu_div_ctrl with a behavioural mantissa divider that
//   raises done 26 cycles after start and holds it until start drops.
// -----------------------------------------------------------------------------
module tb_fpu_div_ctrl;

    logic        clk;
    logic        arst_n;
    logic        start;
    logic [31:0] a_in, b_in;
    logic        busy, done;
    logic [31:0] result;
    logic [3:0]  flags;
    logic [23:0] div_dividend, div_divisor;
    logic        div_start;
    logic        div_done;
    logic [23:0] div_quotient;

    int total = 0;
    int bad   = 0;

    // divider model controls
    logic        mute;   // model never answers
    logic        stale;  // forces div_done high independent of the model
    logic        mdl_done;
    int          mdl_cnt;
    logic [46:0] num;

    fpu_div_ctrl #(.MANT_W(24), .QNAN(32'h7FC00000), .DIV_TIMEOUT(64)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .start        (start),
        .a_in         (a_in),
        .b_in         (b_in),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .flags        (flags),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_start    (div_start),
        .div_done     (div_done),
        .div_quotient (div_quotient)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign div_done = mdl_done | stale;

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mdl_cnt      <= 0;
            mdl_done     <= 1'b0;
            div_quotient <= '0;
        end else if (!div_start) begin
            mdl_cnt  <= 0;
            mdl_done <= 1'b0;
        end else if (!mute) begin
            if (mdl_cnt < 26) mdl_cnt <= mdl_cnt + 1;
            if (mdl_cnt == 25) begin
                mdl_done     <= 1'b1;
                num           = {div_dividend, 23'd0};
                div_quotient <= 24'(num / {23'd0, div_divisor});
            end
        end
    end

    // Launch one operation and observe it. inj_at: cycle index at which a
    // competing start (1.0/0.0) is driven for one cycle while busy (0 = none).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int inj_at,
                          output logic [31:0] res, output logic [3:0] flg,
                          output int lat, output int ndone, output int ds_first,
                          output logic [3:0] flg_at1);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        lat      = 1;
        flg_at1  = flags;
        ds_first = 0;
        ndone    = 0;
        res      = '0;
        flg      = '0;
        if (div_start) ds_first = 1;
        while (!done && lat < 300) begin
            if (lat == inj_at) begin
                start = 1'b1;
                a_in  = 32'h3F800000;
                b_in  = 32'h00000000;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            if (div_start && ds_first == 0) ds_first = lat;
        end
        start = 1'b0;
        if (done) begin
            res   = result;
            flg   = flags;
            ndone = 1;
            repeat (3) begin
                @(posedge clk);
                #1;
                if (done) ndone++;
            end
        end
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, div_start} !== 3'b000) begin
            bad++;
            $display("FAIL reset_ctrl got busy/done/div_start=%b exp=000", {busy, done, div_start});
        end
        total++;
        if ({result, flags, div_dividend, div_divisor} !== 84'd0) begin
            bad++;
            $display("FAIL reset_data got result=%h flags=%b dd=%h ds=%h exp all 0",
                     result, flags, div_dividend, div_divisor);
        end
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_normal();
        logic [31:0] r; logic [3:0] f, f1; int lat, nd, ds;
        logic [31:0] av [5] = '{32'h40C00000, 32'h3F800000, 32'hC0C00000, 32'h7F000000, 32'h00800000};
        logic [31:0] bv [5] = '{32'h40000000, 32'h40400000, 32'h40000000, 32'h3E800000, 32'h40000000};
        logic [31:0] rv [5] = '{32'h40400000, 32'h3EAAAAAA, 32'hC0400000, 32'h7F800000, 32'h00000000};
        logic [3:0]  fv [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            run_op(av[i], bv[i], 0, r, f, lat, nd, ds, f1);
            total++;
            if (r !== rv[i] || f !== fv[i]) begin
                bad++;
                $display("FAIL normal%0d got result=%h flags=%b exp result=%h flags=%b",
                         i, r, f, rv[i], fv[i]);
            end
            total++;
            if (nd != 1 || ds == 0) begin
                bad++;
                $display("FAIL normal%0d_handshake got done_cycles=%0d div_start_seen=%0d exp 1 and nonzero",
                         i, nd, ds);
            end
        end
    endtask

    task automatic test_special();
        logic [31:0] r; logic [3:0] f, f1; int lat, nd, ds;
        logic [31:0] av [8] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 32'h7FC00001,
                                32'hFF800000, 32'h40000000, 32'h80000000, 32'h00400000};
        logic [31:0] bv [8] = '{32'h00000000, 32'h00000000, 32'hFF800000, 32'h3F800000,
                                32'h40000000, 32'hFF800000, 32'h40A00000, 32'h3F800000};
        logic [31:0] rv [8] = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000,
                                32'hFF800000, 32'h80000000, 32'h80000000, 32'h00000000};
        logic [3:0]  fv [8] = '{4'b0100, 4'b1000, 4'b1000, 4'b1000,
                                4'b0000, 4'b0000, 4'b0000, 4'b0000};
        for (int i = 0; i < 8; i++) begin
            run_op(av[i], bv[i], 0, r, f, lat, nd, ds, f1);
            total++;
            if (r !== rv[i] || f !== fv[i]) begin
                bad++;
                $display("FAIL special%0d got result=%h flags=%b exp result=%h flags=%b",
                         i, r, f, rv[i], fv[i]);
            end
            total++;
            if (lat != 3 || nd != 1 || ds != 0) begin
                bad++;
                $display("FAIL special%0d_timing got latency=%0d done_cycles=%0d div_start_at=%0d exp 3/1/0",
                         i, lat, nd, ds);
            end
        end
    endtask

    task automatic test_flag_clear();
        logic [31:0] r; logic [3:0] f, f1; int lat, nd, ds;
        run_op(32'h3F800000, 32'h00000000, 0, r, f, lat, nd, ds, f1);
        run_op(32'h40C00000, 32'h40000000, 0, r, f, lat, nd, ds, f1);
        total++;
        if (f1 !== 4'b0000) begin
            bad++;
            $display("FAIL flag_clear got flags=%b after accepted start exp 0000", f1);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] r; logic [3:0] f, f1; int lat, nd, ds;
        mute = 1'b1;
        run_op(32'h40C00000, 32'h40000000, 0, r, f, lat, nd, ds, f1);
        mute = 1'b0;
        total++;
        if (r !== 32'h7FC00000 || f !== 4'b1000) begin
            bad++;
            $display("FAIL timeout_result got result=%h flags=%b exp 7fc00000/1000", r, f);
        end
        total++;
        if (ds == 0 || (lat - ds) != 64) begin
            bad++;
            $display("FAIL timeout_latency got done %0d cycles after div_start (rise at %0d) exp 64",
                     lat - ds, ds);
        end
        total++;
        if (div_start !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_release got div_start=%b busy=%b exp 0/0", div_start, busy);
        end
    endtask

    task automatic test_async_reset_mid();
        logic [31:0] r; logic [3:0] f, f1; int lat, nd, ds;
        // leave a nonzero result from a completed op so the reset clearing is visible
        run_op(32'h40C00000, 32'h40000000, 0, r, f, lat, nd, ds, f1);
        @(negedge clk);
        a_in  = 32'h3F800000;
        b_in  = 32'h40400000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (div_start !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_wait got div_start=%b busy=%b exp 1/1", div_start, busy);
        end
        #2;
        arst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, div_start, result, flags, div_dividend, div_divisor} !== 87'd0) begin
            bad++;
            $display("FAIL async_reset got busy=%b done=%b ds=%b result=%h flags=%b dd=%h dv=%h exp all 0",
                     busy, done, div_start, result, flags, div_dividend, div_divisor);
        end
        @(negedge clk);
        arst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_op(32'h3F800000, 32'h40400000, 0, r, f, lat, nd, ds, f1);
        total++;
        if (r !== 32'h3EAAAAAA || f !== 4'b0000 || nd != 1) begin
            bad++;
            $display("FAIL after_reset got result=%h flags=%b done_cycles=%0d exp 3eaaaaaa/0000/1", r, f, nd);
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] r; logic [3:0] f, f1; int lat, nd, ds;
        run_op(32'h40C00000, 32'h40000000, 5, r, f, lat, nd, ds, f1);
        total++;
        if (r !== 32'h40400000 || f !== 4'b0000 || nd != 1) begin
            bad++;
            $display("FAIL busy_ignore got result=%h flags=%b done_cycles=%0d exp 40400000/0000/1", r, f, nd);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_ignore_idle got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_stale_done();
        int seen_ds;
        int n;
        stale = 1'b1;
        @(negedge clk);
        a_in  = 32'h40C00000;
        b_in  = 32'h40000000;
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        seen_ds = 0;
        repeat (5) begin
            @(negedge clk);
            if (div_start) seen_ds = 1;
        end
        total++;
        if (seen_ds != 0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL stale_done_hold got div_start_seen=%0d busy=%b exp 0/1", seen_ds, busy);
        end
        stale = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (done !== 1'b1 || result !== 32'h40400000 || flags !== 4'b0000) begin
            bad++;
            $display("FAIL stale_done_finish got done=%b result=%h flags=%b exp 1/40400000/0000",
                     done, result, flags);
        end
    endtask

    initial begin
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        mute  = 1'b0;
        stale = 1'b0;
        test_reset();
        test_normal();
        test_special();
        test_flag_clear();
        test_timeout();
        test_async_reset_mid();
        test_busy_ignore();
        test_stale_done();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
